// File: rtl/iou_pkg.sv
// Shared definitions for the iou_fifo I/O unit: register addresses,
// swx_stat bit positions and the FIFO count-field width helper.
package iou_pkg;

  localparam logic [7:0] ADDR_LED  = 8'h00;
  localparam logic [7:0] ADDR_SWT  = 8'h04;
  localparam logic [7:0] ADDR_RDY  = 8'h08;
  localparam logic [7:0] ADDR_SEG  = 8'h0C;
  localparam logic [7:0] ADDR_STAT = 8'h10;
  localparam logic [7:0] ADDR_SWX  = 8'h14;
  localparam logic [7:0] ADDR_CNT  = 8'h18;

  localparam int unsigned STAT_NEMPTY  = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_OVF     = 2;
  localparam int unsigned STAT_CNT_LSB = 8;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/iou_swx_fifo.sv
// Synchronous word FIFO for committed switch entries. Push on full and pop on
// empty are ignored; a push at full is accepted when a pop happens in the same cycle.
module iou_swx_fifo
  import iou_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;

  // Power-of-2 depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + CNT_W'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/iou_fifo.sv
// Memory-mapped switch/LED/counter I/O unit with a queued hex-entry FIFO.
// Define IOU_DEBOUNCE_EN to add per-input debounce filters after the synchroniser.
module iou_fifo
  import iou_pkg::*;
#(
`ifdef IOU_DEBOUNCE_EN
  parameter int unsigned DEBOUNCE_CYCLES = 16,
`endif
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SW_WIDTH   = 16,
  parameter int unsigned LED_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [7:0]            io_addr,
  input  logic [DATA_WIDTH-1:0] io_dout,
  output logic [DATA_WIDTH-1:0] io_din,
  input  logic                  io_we,
  input  logic                  io_rd,
  output logic [LED_WIDTH-1:0]  led,
  input  logic [SW_WIDTH-1:0]   sw,
  input  logic                  btnr,
  input  logic                  btnc,
  output logic [DATA_WIDTH-1:0] disp_data,
  output logic                  seg_rdy
);

  localparam int unsigned N_IN  = SW_WIDTH + 2;
  localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);

  logic [N_IN-1:0] in_raw, sync1_q, sync2_q, lvl, lvl_prev_q, pulse_q;
  logic [SW_WIDTH-1:0] sw_pulse;
  logic btnr_pulse, btnc_pulse, any_pulse;
  logic we_q, rd_q, we_first, rd_first;
  logic [LED_WIDTH-1:0] led_q;
  logic [DATA_WIDTH-1:0] seg_data_q, cnt_q, edit_q, edit_d;
  logic seg_rdy_q, ovf_q, ovf_d;
  logic [3:0] nib;
  logic commit, pop_req, push_acc;
  logic [DATA_WIDTH-1:0] fifo_rdata, stat;
  logic fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign in_raw = {btnr, btnc, sw};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_prev_q <= '0;
      pulse_q    <= '0;
    end else begin
      sync1_q    <= in_raw;
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl;
      pulse_q    <= lvl & ~lvl_prev_q;
    end
  end

`ifdef IOU_DEBOUNCE_EN
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [N_IN-1:0] filt_q;
  logic [DB_W-1:0] db_cnt_q [N_IN];

  // Filtered level follows the synchronised input only after it has differed
  // for DEBOUNCE_CYCLES consecutive samples.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      filt_q <= '0;
      for (int i = 0; i < int'(N_IN); i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N_IN); i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          filt_q[i]   <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  assign sw_pulse   = pulse_q[SW_WIDTH-1:0];
  assign btnc_pulse = pulse_q[SW_WIDTH];
  assign btnr_pulse = pulse_q[N_IN-1];
  assign any_pulse  = |pulse_q;

  // Strobes may be held for several cycles; side effects fire on the first one.
  assign we_first = io_we & ~we_q;
  assign rd_first = io_rd & ~rd_q;
  assign pop_req  = rd_first & (io_addr == ADDR_SWX);
  assign push_acc = ~fifo_full | (pop_req & ~fifo_empty);

  always_comb begin
    nib = '0;
    for (int i = int'(SW_WIDTH) - 1; i >= 0; i--) begin
      if (sw_pulse[i]) nib = 4'(i);
    end
  end

  always_comb begin
    edit_d = edit_q;
    commit = 1'b0;
    if (|sw_pulse) begin
      edit_d = {edit_q[DATA_WIDTH-5:0], nib};
    end else if (btnr_pulse) begin
      edit_d = edit_q >> 4;
    end else if (btnc_pulse) begin
      commit = 1'b1;
      if (push_acc) edit_d = '0;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (commit && !push_acc)                          ovf_d = 1'b1;
    else if (rd_first && (io_addr == ADDR_STAT))      ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_q       <= 1'b0;
      rd_q       <= 1'b0;
      led_q      <= '0;
      seg_data_q <= '0;
      seg_rdy_q  <= 1'b1;
      cnt_q      <= '0;
      edit_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      we_q   <= io_we;
      rd_q   <= io_rd;
      edit_q <= edit_d;
      ovf_q  <= ovf_d;
      if (io_we && (io_addr == ADDR_LED)) led_q <= io_dout[LED_WIDTH-1:0];
      if (we_first && (io_addr == ADDR_SEG)) begin
        seg_data_q <= io_dout;
        seg_rdy_q  <= 1'b0;
      end else if (any_pulse) begin
        seg_rdy_q  <= 1'b1;
      end
      if (io_we && (io_addr == ADDR_CNT)) cnt_q <= io_dout;
      else                                cnt_q <= cnt_q + DATA_WIDTH'(1);
    end
  end

  iou_swx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_swx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (commit),
    .wdata (edit_q),
    .pop   (pop_req),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    stat                             = '0;
    stat[STAT_NEMPTY]                = ~fifo_empty;
    stat[STAT_FULL]                  = fifo_full;
    stat[STAT_OVF]                   = ovf_q;
    stat[STAT_CNT_LSB +: CNT_W]      = fifo_count;
  end

  always_comb begin
    io_din = '0;
    case (io_addr)
      ADDR_SWT:  io_din = DATA_WIDTH'(in_raw);
      ADDR_RDY:  io_din[0] = seg_rdy_q;
      ADDR_STAT: io_din = stat;
      ADDR_SWX:  io_din = fifo_rdata;
      ADDR_CNT:  io_din = cnt_q;
      default:   io_din = '0;
    endcase
  end

  assign led       = led_q;
  assign seg_rdy   = seg_rdy_q;
  assign disp_data = seg_rdy_q ? edit_q : seg_data_q;

endmodule
